// File: rtl/life_gen_stepper.sv
// One Game of Life (B3/S23) generation over a FIELD_W x FIELD_H field.
// Cells are scanned row-major; each cell costs 9 reads, 1 evaluate and 1 write cycle.
//
// state | meaning
// IDLE  | waiting for i_start
// READ  | slot 0..7 neighbour reads, slot 8 centre read
// EVAL  | centre returns, next state computed
// WRITE | next state presented on the write port
// DONE  | o_done pulse, generation counter advanced

module get_nbrs_address #(
  parameter int FIELD_W = 50,
  parameter int FIELD_H = 50,
  parameter int XW = $clog2(FIELD_W),
  parameter int YW = $clog2(FIELD_H)
) (
  input  logic [XW-1:0]   i_x,
  input  logic [YW-1:0]   i_y,
  output logic [8*XW-1:0] o_nbrs_x,
  output logic [8*YW-1:0] o_nbrs_y,
  output logic [7:0]      o_nbrs_rlvnt
);
  localparam logic [XW-1:0] X_MAX = XW'(FIELD_W - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(FIELD_H - 1);
  localparam logic [XW-1:0] X_ONE = XW'(1);
  localparam logic [YW-1:0] Y_ONE = YW'(1);

  logic has_l, has_r, has_u, has_d;
  logic [XW-1:0] xl, xr;
  logic [YW-1:0] yu, yd;

  always_comb begin
    has_l = (i_x != '0);
    has_r = (i_x != X_MAX);
    has_u = (i_y != '0);
    has_d = (i_y != Y_MAX);
    xl = i_x - X_ONE;
    xr = i_x + X_ONE;
    yu = i_y - Y_ONE;
    yd = i_y + Y_ONE;
    // index layout: 0 1 2 / 3 x 4 / 5 6 7, y grows downward
    o_nbrs_x = {xr, i_x, xl, xr, xl, xr, i_x, xl};
    o_nbrs_y = {yd, yd, yd, i_y, i_y, yu, yu, yu};
    o_nbrs_rlvnt = {has_r & has_d, has_d, has_l & has_d, has_r, has_l,
                    has_r & has_u, has_u, has_l & has_u};
  end
endmodule

module life_gen_stepper #(
  parameter int FIELD_W = 50,
  parameter int FIELD_H = 50,
  parameter int XW = $clog2(FIELD_W),
  parameter int YW = $clog2(FIELD_H)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_rd_en,
  output logic [XW-1:0] o_rd_x,
  output logic [YW-1:0] o_rd_y,
  input  logic          i_rd_data,
  output logic          o_wr_en,
  output logic [XW-1:0] o_wr_x,
  output logic [YW-1:0] o_wr_y,
  output logic          o_wr_data,
  output logic [15:0]   o_gen_cnt
);
  localparam logic [XW-1:0] X_MAX = XW'(FIELD_W - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(FIELD_H - 1);
  localparam logic [YW-1:0] Y_ONE = YW'(1);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_EVAL, S_WRITE, S_DONE} state_t;

  state_t        state;
  logic [3:0]    slot;
  logic [3:0]    cnt;
  logic          prev_nbr;
  logic          last_cell;
  logic [XW-1:0] cur_x;
  logic [YW-1:0] cur_y;

  logic [8*XW-1:0] nbrs_x;
  logic [8*YW-1:0] nbrs_y;
  logic [7:0]      nbrs_rlvnt;

  logic [3:0]    sel_idx;
  logic          sel_en;
  logic [XW-1:0] sel_x;
  logic [YW-1:0] sel_y;
  logic          next_alive;
  logic          cur_is_last;

  get_nbrs_address #(.FIELD_W(FIELD_W), .FIELD_H(FIELD_H), .XW(XW), .YW(YW)) u_nbrs (
    .i_x          (cur_x),
    .i_y          (cur_y),
    .o_nbrs_x     (nbrs_x),
    .o_nbrs_y     (nbrs_y),
    .o_nbrs_rlvnt (nbrs_rlvnt)
  );

  // Address for the slot presented in the next cycle; cur_x/cur_y already
  // point at the upcoming cell while in IDLE or WRITE.
  always_comb begin
    sel_idx = (state == S_READ) ? slot + 4'd1 : 4'd0;
    sel_en  = 1'b1;
    sel_x   = cur_x;
    sel_y   = cur_y;
    if (sel_idx < 4'd8) begin
      sel_en = nbrs_rlvnt[sel_idx[2:0]];
      sel_x  = sel_en ? nbrs_x[sel_idx[2:0]*XW +: XW] : '0;
      sel_y  = sel_en ? nbrs_y[sel_idx[2:0]*YW +: YW] : '0;
    end
    next_alive  = (cnt == 4'd3) | (i_rd_data & (cnt == 4'd2));
    cur_is_last = (cur_x == X_MAX) && (cur_y == Y_MAX);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= S_IDLE;
      slot      <= '0;
      cnt       <= '0;
      prev_nbr  <= 1'b0;
      last_cell <= 1'b0;
      cur_x     <= '0;
      cur_y     <= '0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_rd_en   <= 1'b0;
      o_rd_x    <= '0;
      o_rd_y    <= '0;
      o_wr_en   <= 1'b0;
      o_wr_x    <= '0;
      o_wr_y    <= '0;
      o_wr_data <= 1'b0;
      o_gen_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_start) begin
            state    <= S_READ;
            o_busy   <= 1'b1;
            slot     <= '0;
            cnt      <= '0;
            prev_nbr <= 1'b0;
            o_rd_en  <= sel_en;
            o_rd_x   <= sel_x;
            o_rd_y   <= sel_y;
          end
        end
        S_READ: begin
          // data on i_rd_data belongs to the previous slot
          if (prev_nbr) cnt <= cnt + {3'b000, i_rd_data};
          prev_nbr <= o_rd_en && (slot != 4'd8);
          if (slot == 4'd8) begin
            state   <= S_EVAL;
            o_rd_en <= 1'b0;
            o_rd_x  <= '0;
            o_rd_y  <= '0;
          end else begin
            slot    <= slot + 4'd1;
            o_rd_en <= sel_en;
            o_rd_x  <= sel_x;
            o_rd_y  <= sel_y;
          end
        end
        S_EVAL: begin
          state     <= S_WRITE;
          o_wr_en   <= 1'b1;
          o_wr_x    <= cur_x;
          o_wr_y    <= cur_y;
          o_wr_data <= next_alive;
          last_cell <= cur_is_last;
          if (cur_x == X_MAX) begin
            cur_x <= '0;
            cur_y <= (cur_y == Y_MAX) ? '0 : cur_y + Y_ONE;
          end else begin
            cur_x <= cur_x + XW'(1);
          end
        end
        S_WRITE: begin
          o_wr_en   <= 1'b0;
          o_wr_data <= 1'b0;
          if (last_cell) begin
            state     <= S_DONE;
            o_done    <= 1'b1;
            o_gen_cnt <= o_gen_cnt + 16'd1;
          end else begin
            state    <= S_READ;
            slot     <= '0;
            cnt      <= '0;
            prev_nbr <= 1'b0;
            o_rd_en  <= sel_en;
            o_rd_x   <= sel_x;
            o_rd_y   <= sel_y;
          end
        end
        S_DONE: begin
          state  <= S_IDLE;
          o_done <= 1'b0;
          o_busy <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/life_gen_stepper.md
# life_gen_stepper

Sequential engine that computes one Game of Life generation (rule B3/S23) over a FIELD_W × FIELD_H field. On a start pulse it scans every cell in row-major order. For each cell it reads the 8 neighbours and the cell itself from the current-generation memory, counts live neighbours, and writes the next state to the next-generation memory. It sits directly downstream of `get_nbrs_address`, which it instantiates to obtain neighbour coordinates and relevance flags. Its read/write ports connect to the field double-buffer.

## Interface

Parameters:
- FIELD_W, default 50: field width in cells. Must be ≥ 2.
- FIELD_H, default 50: field height in cells. Must be ≥ 2.

Ports. XW = $clog2(FIELD_W), YW = $clog2(FIELD_H).
- i_clk, input, 1: the only clock.
- i_rst, input, 1: asynchronous, active-high reset.
- i_start, input, 1: request to compute one generation. Sampled only in IDLE.
- o_busy, output, 1: high from the cycle after start is accepted until DONE, inclusive.
- o_done, output, 1: one-cycle pulse when the generation is finished.
- o_rd_en, output, 1: read strobe to the current-generation memory.
- o_rd_x, output, XW: read column.
- o_rd_y, output, YW: read row.
- i_rd_data, input, 1: read data. Valid exactly 1 cycle after the o_rd_en cycle.
- o_wr_en, output, 1: write strobe to the next-generation memory.
- o_wr_x, output, XW: write column.
- o_wr_y, output, YW: write row.
- o_wr_data, output, 1: next state of the cell (1 = alive).
- o_gen_cnt, output, 16: number of completed generations. Wraps from 65535 to 0.

## Operation

- States:
  - IDLE: waits for i_start.
  - READ: 9 cycles, slot k = 0..8.
  - EVAL: 1 cycle.
  - WRITE: 1 cycle.
  - DONE: 1 cycle, then returns to IDLE.
- Read slot order:
  - Slots 0..7 are the neighbour indices from `get_nbrs_address`, numbered 0 1 2 / 3 x 4 / 5 6 7, with y increasing downward.
  - Slot 8 is the centre cell.
- Irrelevant neighbours:
  - A neighbour whose o_nbrs_rlvnt is 0 still consumes its slot cycle.
  - During that slot o_rd_en = 0 and o_rd_x/o_rd_y are driven 0.
  - The returned data for that slot is ignored and contributes 0.
- Neighbour counter:
  - 4-bit counter, cleared when entering READ for each cell.
  - Adds i_rd_data for slots 0..7 only, and only if the slot issued a read.
- Centre value: captured from i_rd_data in EVAL (the return of slot 8).
- Next-state rule: next = (cnt == 3) | (centre & cnt == 2).
- Scan order:
  - x increments first. When x reaches FIELD_W−1 it wraps to 0 and y increments.
  - After the cell (FIELD_W−1, FIELD_H−1) is written, the FSM enters DONE.
- No toroidal wrap: cells outside the field count as dead.
- i_start asserted while busy is ignored. It is not queued.
- DONE:
  - o_done pulses and o_gen_cnt increments in the same cycle.
  - The FSM returns to IDLE. A new i_start is accepted on the next cycle.
- Mid-operation reset:
  - All state clears immediately.
  - No further writes occur. The partially written next-generation buffer is left as is.

## Timing

- All outputs are registered.
- Reset values: every output is 0, o_gen_cnt is 0, and the state is IDLE.
- Start acceptance: i_start is high in IDLE at edge 0. o_busy and the first o_rd_en (slot 0 of cell (0,0)) appear after that edge, in cycle 1.
- Cell n (row-major index) timing:
  - Reads occupy cycles 11n+1 through 11n+9.
  - EVAL is cycle 11n+10.
  - o_wr_en is high in cycle 11n+11, for exactly one cycle.
- Per-cell cost: 11 cycles.
- The memory is never read and written in the same cycle by this block.
- o_done is high in cycle 11·W·H+1. o_busy falls in the following cycle.
- One generation therefore takes 11·W·H+1 cycles from start to done.

## Test plan

- Blinker, W = H = 5. Alive cells: (2,1), (2,2), (2,3).
  - Writes show alive only at (1,2), (2,2), (3,2). All other 22 cells are written 0.
  - o_done occurs in cycle 276.
  - o_gen_cnt = 1 afterwards.
- Block still-life at corner (0,0)–(1,1), W = H = 4.
  - The four block cells are written 1 and all others 0.
  - For cell (0,0), o_rd_en = 0 in slots 0, 1, 2, 3 and 5.
- All-alive 4×4 field.
  - Only the four corners are written 1; they have 3 neighbours.
  - Edge cells (5 neighbours) and inner cells (8 neighbours) are written 0.
- Start while busy, W = H = 4.
  - Pulse i_start again at cycle 40.
  - Exactly 16 writes and one o_done occur (cycle 177). o_gen_cnt = 1.
- Reset mid-generation, W = H = 5.
  - Assert i_rst at cycle 50. All outputs drop to 0 without waiting for a clock edge, and no writes follow.
  - After release, a new i_start produces a first read at cell (0,0), slot 0, and o_gen_cnt ends at 1.
- Counter wrap: preload, or run 65536 generations on a 2×2 field. o_gen_cnt goes from 65535 to 0.
